// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline control unit.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_EXT = 4'd11;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_LT   = 3'd2,
    BR_GE   = 3'd3,
    BR_LTU  = 3'd4,
    BR_GEU  = 3'd5,
    BR_NONE = 3'd6,
    BR_UNC  = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    WB_PC4 = 2'd0,
    WB_ALU = 2'd1,
    WB_MEM = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic       valid;
    alu_op_e    alu;
    br_type_e   br;
    logic [2:0] load;
    logic [1:0] store;
    wb_sel_e    wb;
    logic       reg_write;
    logic       mem_wr;
    logic       mem_rd;
    logic       sel_a;
    logic       sel_b;
    logic       csr_wr;
    logic       csr_rd;
    csr_op_e    csr_op;
    logic       csr_imm;
    logic       mret;
    logic       trap;
    logic       trap_irq;
    logic [3:0] cause;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{
    valid: 1'b0, alu: ALU_ADD, br: BR_NONE, load: LD_NONE, store: ST_NONE,
    wb: WB_PC4, reg_write: 1'b0, mem_wr: 1'b0, mem_rd: 1'b0, sel_a: 1'b0,
    sel_b: 1'b0, csr_wr: 1'b0, csr_rd: 1'b0, csr_op: CSR_NONE, csr_imm: 1'b0,
    mret: 1'b0, trap: 1'b0, trap_irq: 1'b0, cause: 4'd0
  };

  function automatic ctrl_bundle_t trap_bundle(input logic [3:0] cause, input logic irq);
    ctrl_bundle_t b;
    b          = BUBBLE;
    b.valid    = 1'b1;
    b.trap     = 1'b1;
    b.trap_irq = irq;
    b.cause    = cause;
    return b;
  endfunction

  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e alu_mext(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational RV32I/M/Zicsr decoder: instruction word to control bundle plus trap flags.
module pipe_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1,
  parameter bit EN_CSRI = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         ecall,
  output logic         ebreak,
  output logic         mret,
  output logic         is_div
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [11:0] imm12;
  logic        wr_rd;
  ctrl_bundle_t d;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rs1   = instr[19:15];
  assign imm12 = instr[31:20];
  // Writes to x0 are dropped here so the register file never sees them.
  assign wr_rd = (instr[11:7] != 5'd0);

  always_comb begin
    d       = BUBBLE;
    d.valid = 1'b1;
    illegal = 1'b0;
    ecall   = 1'b0;
    ebreak  = 1'b0;
    mret    = 1'b0;
    is_div  = 1'b0;
    case (opc)
      OPC_LUI: begin
        d.alu = ALU_PASSB; d.sel_b = 1'b1; d.wb = WB_ALU; d.reg_write = wr_rd;
      end
      OPC_AUIPC: begin
        d.sel_a = 1'b1; d.sel_b = 1'b1; d.wb = WB_ALU; d.reg_write = wr_rd;
      end
      OPC_JAL: begin
        d.br = BR_UNC; d.sel_a = 1'b1; d.sel_b = 1'b1; d.wb = WB_PC4; d.reg_write = wr_rd;
      end
      OPC_JALR: begin
        d.br = BR_UNC; d.sel_b = 1'b1; d.wb = WB_PC4; d.reg_write = wr_rd;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        d.sel_a = 1'b1; d.sel_b = 1'b1;
        case (f3)
          3'b000:  d.br = BR_EQ;
          3'b001:  d.br = BR_NE;
          3'b100:  d.br = BR_LT;
          3'b101:  d.br = BR_GE;
          3'b110:  d.br = BR_LTU;
          3'b111:  d.br = BR_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.mem_rd = 1'b1; d.sel_b = 1'b1; d.wb = WB_MEM; d.reg_write = wr_rd;
        case (f3)
          3'b000:  d.load = LD_LB;
          3'b001:  d.load = LD_LH;
          3'b010:  d.load = LD_LW;
          3'b100:  d.load = LD_LBU;
          3'b101:  d.load = LD_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.mem_wr = 1'b1; d.sel_b = 1'b1;
        if (f3[2] || f3[1:0] == 2'b11) illegal = 1'b1;
        else d.store = f3[1:0] + 2'd1;
      end
      OPC_OPIMM: begin
        d.sel_b = 1'b1; d.wb = WB_ALU; d.reg_write = wr_rd;
        d.alu   = alu_base(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
      end
      OPC_OP: begin
        d.wb = WB_ALU; d.reg_write = wr_rd;
        if (f7 == 7'b0000000) begin
          d.alu = alu_base(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          d.alu = alu_base(f3, 1'b1);
        end else if (f7 == 7'b0000001 && EN_MEXT) begin
          d.alu  = alu_mext(f3);
          is_div = f3[2];
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          case (imm12)
            12'h000: ecall  = 1'b1;
            12'h001: ebreak = 1'b1;
            12'h302: mret   = 1'b1;
            12'h105: ;
            default: illegal = 1'b1;
          endcase
        end else if (f3 == 3'b100 || (f3[2] && !EN_CSRI)) begin
          illegal = 1'b1;
        end else begin
          d.csr_op    = csr_op_e'(f3[1:0]);
          d.csr_imm   = f3[2];
          d.csr_rd    = 1'b1;
          d.csr_wr    = !(f3[1] && rs1 == 5'd0);
          d.wb        = WB_CSR;
          d.reg_write = wr_rd;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl   = trap_bundle(CAUSE_ILLEGAL, 1'b0);
      is_div = 1'b0;
    end else if (ecall) begin
      ctrl = trap_bundle(CAUSE_ECALL_M, 1'b0);
    end else if (ebreak) begin
      ctrl = trap_bundle(CAUSE_BREAK, 1'b0);
    end else if (mret) begin
      ctrl       = BUBBLE;
      ctrl.valid = 1'b1;
      ctrl.mret  = 1'b1;
    end else begin
      ctrl = d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Registered ID/EX control bundle with divide-busy and trap/return sequencing.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter bit          EN_MEXT    = 1'b1,
  parameter int unsigned DIV_CYCLES = 32,
  parameter bit          EN_CSRI    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        irq_i,
  output logic        ctrl_valid_o,
  output logic [4:0]  alu_ctrl_o,
  output logic [2:0]  br_type_o,
  output logic [2:0]  load_o,
  output logic [1:0]  store_o,
  output logic [1:0]  wb_sel_o,
  output logic        reg_write_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  output logic        sel_a_o,
  output logic        sel_b_o,
  output logic        csr_wr_en_o,
  output logic        csr_rd_en_o,
  output logic [1:0]  csr_op_o,
  output logic        csr_imm_o,
  output logic        mret_o,
  output logic        trap_o,
  output logic        trap_irq_o,
  output logic [3:0]  trap_cause_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {ST_RUN, ST_MDIV, ST_TRAP} state_e;

  localparam int unsigned   CW       = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 2);

  state_e       state;
  logic [CW-1:0] cnt;
  logic         busy;
  ctrl_bundle_t q;
  ctrl_bundle_t dec;
  logic         dec_illegal, dec_ecall, dec_ebreak, dec_mret, dec_div;

  pipe_ctrl_decode #(
    .EN_MEXT (EN_MEXT),
    .EN_CSRI (EN_CSRI)
  ) u_decode (
    .instr   (instr_i),
    .ctrl    (dec),
    .illegal (dec_illegal),
    .ecall   (dec_ecall),
    .ebreak  (dec_ebreak),
    .mret    (dec_mret),
    .is_div  (dec_div)
  );

  assign instr_ready_o = (state == ST_RUN) && !stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      q     <= BUBBLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (flush_i) begin
      state <= ST_RUN;
      q     <= BUBBLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        // Leaves MDIV one cycle early; the held bundle and busy cover the final
        // cycle, during which the next instruction can already be accepted.
        ST_MDIV: begin
          if (cnt == CNT_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_TRAP: begin
          state <= ST_RUN;
          q     <= BUBBLE;
          busy  <= 1'b0;
        end
        default: begin
          if (!stall_i) begin
            if (instr_valid_i && irq_i) begin
              q     <= trap_bundle(CAUSE_IRQ_EXT, 1'b1);
              busy  <= 1'b0;
              state <= ST_TRAP;
            end else if (instr_valid_i) begin
              q    <= dec;
              busy <= dec_div;
              if (dec_illegal || dec_ecall || dec_ebreak || dec_mret) begin
                state <= ST_TRAP;
              end else if (dec_div) begin
                state <= ST_MDIV;
                cnt   <= '0;
              end
            end else begin
              q    <= BUBBLE;
              busy <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign ctrl_valid_o = q.valid;
  assign alu_ctrl_o   = q.alu;
  assign br_type_o    = q.br;
  assign load_o       = q.load;
  assign store_o      = q.store;
  assign wb_sel_o     = q.wb;
  assign reg_write_o  = q.reg_write;
  assign mem_wr_o     = q.mem_wr;
  assign mem_rd_o     = q.mem_rd;
  assign sel_a_o      = q.sel_a;
  assign sel_b_o      = q.sel_b;
  assign csr_wr_en_o  = q.csr_wr;
  assign csr_rd_en_o  = q.csr_rd;
  assign csr_op_o     = q.csr_op;
  assign csr_imm_o    = q.csr_imm;
  assign mret_o       = q.mret;
  assign trap_o       = q.trap;
  assign trap_irq_o   = q.trap_irq;
  assign trap_cause_o = q.cause;
  assign busy_o       = busy;

endmodule
